// File: rtl/conv_window_sequencer.sv
// KxK valid-only window scanner feeding the Gabor MAC ALU: issues pixel/coefficient
// reads one tap per cycle and presents aligned pixel/coefficient pairs with a last-tap flag.
module conv_window_sequencer #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int K       = 5,
  parameter int ADDR_W  = 12,
  parameter int KADDR_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic               pix_rd_en,
  input  logic [DATA_W-1:0]  pix_rd_data,
  output logic [KADDR_W-1:0] coef_addr,
  input  logic [DATA_W-1:0]  coef_data,
  output logic [DATA_W-1:0]  read_data,
  output logic [DATA_W-1:0]  kernel_val,
  output logic               pixel_valid,
  output logic [15:0]        win_x,
  output logic [15:0]        win_y,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [15:0]       K_LAST   = 16'(K - 1);
  localparam logic [15:0]       WX_LAST  = 16'(IMG_W - K);
  localparam logic [15:0]       WY_LAST  = 16'(IMG_H - K);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e state_q, state_d;
  logic   drain_q, drain_d;

  logic [15:0] kx_q, kx_d;
  logic [15:0] ky_q, ky_d;
  logic [15:0] wx_q, wx_d;
  logic [15:0] wy_q, wy_d;

  // addr = row_base + kx, row_base = win_base + ky*IMG_W, win_base = wrow + wx, wrow = wy*IMG_W
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0]  win_base_q, win_base_d;
  logic [ADDR_W-1:0]  wrow_q, wrow_d;
  logic [KADDR_W-1:0] coef_q, coef_d;

  logic        tv1_q, tv1_d;
  logic        lt1_q, lt1_d;
  logic [15:0] wx1_q, wx1_d;
  logic [15:0] wy1_q, wy1_d;

  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] kernel_val_q, kernel_val_d;
  logic              pv_q, pv_d;
  logic [15:0]       win_x_q, win_x_d;
  logic [15:0]       win_y_q, win_y_d;

  logic tap;
  logic kx_end, ky_end, wx_end, wy_end;
  logic last_tap;

  assign tap      = (state_q == S_RUN);
  assign kx_end   = (kx_q == K_LAST);
  assign ky_end   = (ky_q == K_LAST);
  assign wx_end   = (wx_q == WX_LAST);
  assign wy_end   = (wy_q == WY_LAST);
  assign last_tap = tap & kx_end & ky_end;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    wx_d       = wx_q;
    wy_d       = wy_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    win_base_d = win_base_q;
    wrow_d     = wrow_q;
    coef_d     = coef_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end

      S_RUN: begin
        if (!kx_end) begin
          kx_d   = kx_q + 16'd1;
          addr_d = addr_q + ADDR_ONE;
          coef_d = coef_q + KADDR_W'(1);
        end else if (!ky_end) begin
          kx_d       = '0;
          ky_d       = ky_q + 16'd1;
          row_base_d = row_base_q + ROW_STEP;
          addr_d     = row_base_q + ROW_STEP;
          coef_d     = coef_q + KADDR_W'(1);
        end else if (!wx_end) begin
          kx_d       = '0;
          ky_d       = '0;
          coef_d     = '0;
          wx_d       = wx_q + 16'd1;
          win_base_d = win_base_q + ADDR_ONE;
          row_base_d = win_base_q + ADDR_ONE;
          addr_d     = win_base_q + ADDR_ONE;
        end else if (!wy_end) begin
          kx_d       = '0;
          ky_d       = '0;
          coef_d     = '0;
          wx_d       = '0;
          wy_d       = wy_q + 16'd1;
          wrow_d     = wrow_q + ROW_STEP;
          win_base_d = wrow_q + ROW_STEP;
          row_base_d = wrow_q + ROW_STEP;
          addr_d     = wrow_q + ROW_STEP;
        end else begin
          // Final tap of the frame: rewind so IDLE/DRAIN present a zero address.
          kx_d       = '0;
          ky_d       = '0;
          wx_d       = '0;
          wy_d       = '0;
          coef_d     = '0;
          addr_d     = '0;
          row_base_d = '0;
          win_base_d = '0;
          wrow_d     = '0;
          drain_d    = 1'b0;
          state_d    = S_DRAIN;
        end
      end

      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tap flags and window tag follow the RAM/ROM read latency, then gate the ALU operands.
  always_comb begin
    tv1_d        = tap;
    lt1_d        = last_tap;
    wx1_d        = wx_q;
    wy1_d        = wy_q;
    read_data_d  = tv1_q ? pix_rd_data : '0;
    kernel_val_d = tv1_q ? coef_data : '0;
    pv_d         = tv1_q & lt1_q;
    win_x_d      = pv_d ? wx1_q : win_x_q;
    win_y_d      = pv_d ? wy1_q : win_y_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      drain_q      <= 1'b0;
      kx_q         <= '0;
      ky_q         <= '0;
      wx_q         <= '0;
      wy_q         <= '0;
      addr_q       <= '0;
      row_base_q   <= '0;
      win_base_q   <= '0;
      wrow_q       <= '0;
      coef_q       <= '0;
      tv1_q        <= 1'b0;
      lt1_q        <= 1'b0;
      wx1_q        <= '0;
      wy1_q        <= '0;
      read_data_q  <= '0;
      kernel_val_q <= '0;
      pv_q         <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      addr_q       <= addr_d;
      row_base_q   <= row_base_d;
      win_base_q   <= win_base_d;
      wrow_q       <= wrow_d;
      coef_q       <= coef_d;
      tv1_q        <= tv1_d;
      lt1_q        <= lt1_d;
      wx1_q        <= wx1_d;
      wy1_q        <= wy1_d;
      read_data_q  <= read_data_d;
      kernel_val_q <= kernel_val_d;
      pv_q         <= pv_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
    end
  end

  assign pix_addr    = addr_q;
  assign pix_rd_en   = tap;
  assign coef_addr   = coef_q;
  assign read_data   = read_data_q;
  assign kernel_val  = kernel_val_q;
  assign pixel_valid = pv_q;
  assign win_x       = win_x_q;
  assign win_y       = win_y_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: cycle table for a 6x5/K=3 frame plus a window scoreboard
// (coordinates, accumulated MAC result, pixel_valid cycle) on a 6x5/K=3 and a 4x4/K=1 instance.
module tb_conv_window_sequencer;

  localparam int AW = 6;
  localparam int AH = 5;
  localparam int AK = 3;
  localparam int BW = 4;
  localparam int BH = 4;
  localparam int BK = 1;

  typedef struct {
    int     wx;
    int     wy;
    longint sum;
    int     cyc;
  } win_t;

  typedef struct {
    int rel;
    int addr;
    int coef;
    int en;
    int busy;
    int pv;
    int done;
    int rd;
    int kv;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pix_mode = 0;
  int   coef_mode = 0;

  logic        start_a, pix_rd_en_a, pixel_valid_a, busy_a, done_a;
  logic [11:0] pix_addr_a;
  logic [4:0]  coef_addr_a;
  logic [31:0] pix_rd_data_a = '0, coef_data_a = '0, read_data_a, kernel_val_a;
  logic [15:0] win_x_a, win_y_a;

  logic        start_b, pix_rd_en_b, pixel_valid_b, busy_b, done_b;
  logic [11:0] pix_addr_b;
  logic [4:0]  coef_addr_b;
  logic [31:0] pix_rd_data_b = '0, coef_data_b = '0, read_data_b, kernel_val_b;
  logic [15:0] win_x_b, win_y_b;

  win_t   q_a[$];
  win_t   q_b[$];
  longint acc_a = 0, acc_b = 0;
  int     pv_cnt_a = 0, pv_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  vec_t   tab[16];

  conv_window_sequencer #(.IMG_W(AW), .IMG_H(AH), .K(AK), .ADDR_W(12), .KADDR_W(5), .DATA_W(32)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .pix_addr(pix_addr_a), .pix_rd_en(pix_rd_en_a), .pix_rd_data(pix_rd_data_a),
    .coef_addr(coef_addr_a), .coef_data(coef_data_a),
    .read_data(read_data_a), .kernel_val(kernel_val_a), .pixel_valid(pixel_valid_a),
    .win_x(win_x_a), .win_y(win_y_a), .busy(busy_a), .done(done_a)
  );

  conv_window_sequencer #(.IMG_W(BW), .IMG_H(BH), .K(BK), .ADDR_W(12), .KADDR_W(5), .DATA_W(32)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .pix_addr(pix_addr_b), .pix_rd_en(pix_rd_en_b), .pix_rd_data(pix_rd_data_b),
    .coef_addr(coef_addr_b), .coef_data(coef_data_b),
    .read_data(read_data_b), .kernel_val(kernel_val_b), .pixel_valid(pixel_valid_b),
    .win_x(win_x_b), .win_y(win_y_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pix_val(input logic [11:0] a);
    return (pix_mode == 1) ? 32'd5 : {20'd0, a};
  endfunction

  function automatic logic [31:0] coef_val();
    return (coef_mode == 1) ? 32'hFFFF_FFFF : 32'd1;
  endfunction

  // Synchronous pixel RAM and coefficient ROM models, one cycle of read latency.
  always @(posedge clk) begin
    if (pix_rd_en_a) pix_rd_data_a <= pix_val(pix_addr_a);
    if (pix_rd_en_b) pix_rd_data_b <= pix_val(pix_addr_b);
    coef_data_a <= coef_val();
    coef_data_b <= coef_val();
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int w, input int h, input int k, input int t0, input bit to_b);
    win_t e;
    int   idx;
    idx = 0;
    for (int wy = 0; wy <= h - k; wy++) begin
      for (int wx = 0; wx <= w - k; wx++) begin
        e.wx  = wx;
        e.wy  = wy;
        e.sum = 0;
        for (int ky = 0; ky < k; ky++) begin
          for (int kx = 0; kx < k; kx++) begin
            e.sum += longint'((pix_mode == 1) ? 5 : (wy + ky) * w + wx + kx) *
                     longint'((coef_mode == 1) ? -1 : 1);
          end
        end
        idx++;
        e.cyc = t0 + idx * k * k + 1;
        if (to_b) q_b.push_back(e);
        else q_a.push_back(e);
      end
    end
  endtask

  // Free-running ALU models: accumulate every cycle, score and clear on pixel_valid.
  always @(negedge clk) begin
    win_t e;
    if (reset) begin
      acc_a = 0;
    end else begin
      acc_a += longint'($signed(read_data_a)) * longint'($signed(kernel_val_a));
      if (!busy_a) chk("idle_data_a", longint'(read_data_a | kernel_val_a), 0);
      if (done_a) done_cnt_a++;
      if (pixel_valid_a) begin
        pv_cnt_a++;
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pv_a_unexpected: pixel_valid with no window expected (cycle %0d)", cyc);
        end else begin
          e = q_a.pop_front();
          chk("win_x_a", longint'(win_x_a), longint'(e.wx));
          chk("win_y_a", longint'(win_y_a), longint'(e.wy));
          chk("sum_a", acc_a, e.sum);
          chk("pv_cycle_a", longint'(cyc), longint'(e.cyc));
        end
        acc_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    win_t e;
    if (reset) begin
      acc_b = 0;
    end else begin
      acc_b += longint'($signed(read_data_b)) * longint'($signed(kernel_val_b));
      if (!busy_b) chk("idle_data_b", longint'(read_data_b | kernel_val_b), 0);
      if (done_b) done_cnt_b++;
      if (pixel_valid_b) begin
        pv_cnt_b++;
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pv_b_unexpected: pixel_valid with no window expected (cycle %0d)", cyc);
        end else begin
          e = q_b.pop_front();
          chk("win_x_b", longint'(win_x_b), longint'(e.wx));
          chk("win_y_b", longint'(win_y_b), longint'(e.wy));
          chk("sum_b", acc_b, e.sum);
          chk("pv_cycle_b", longint'(cyc), longint'(e.cyc));
        end
        acc_b = 0;
      end
    end
  end

  // Called just after a negedge with dut_a idle; start is sampled at the next edge (E0).
  task automatic run_t1(input string tag);
    int pv0, dn0, en_cnt;
    pv0       = pv_cnt_a;
    dn0       = done_cnt_a;
    en_cnt    = 0;
    pix_mode  = 0;
    coef_mode = 0;
    start_a   = 1'b1;
    push_frame(AW, AH, AK, cyc + 1, 1'b0);
    for (int rel = 0; rel <= 112; rel++) begin
      if (rel > 0) @(negedge clk);
      if (rel == 1) start_a = 1'b0;
      if (rel >= 1 && rel <= 108 && pix_rd_en_a) en_cnt++;
      foreach (tab[i]) begin
        if (tab[i].rel == rel) begin
          chk($sformatf("%s_addr@%0d", tag, rel), longint'(pix_addr_a), longint'(tab[i].addr));
          chk($sformatf("%s_coef@%0d", tag, rel), longint'(coef_addr_a), longint'(tab[i].coef));
          chk($sformatf("%s_rden@%0d", tag, rel), longint'(pix_rd_en_a), longint'(tab[i].en));
          chk($sformatf("%s_busy@%0d", tag, rel), longint'(busy_a), longint'(tab[i].busy));
          chk($sformatf("%s_pv@%0d", tag, rel), longint'(pixel_valid_a), longint'(tab[i].pv));
          chk($sformatf("%s_done@%0d", tag, rel), longint'(done_a), longint'(tab[i].done));
          chk($sformatf("%s_rd@%0d", tag, rel), longint'(read_data_a), longint'(tab[i].rd));
          chk($sformatf("%s_kv@%0d", tag, rel), longint'(kernel_val_a), longint'(tab[i].kv));
        end
      end
    end
    chk({tag, "_rden_count"}, longint'(en_cnt), 108);
    chk({tag, "_pv_count"}, longint'(pv_cnt_a - pv0), 12);
    chk({tag, "_done_count"}, longint'(done_cnt_a - dn0), 1);
  endtask

  task automatic frame_a(input string tag, input int pm, input int cm, input int pulse_rel);
    int pv0, dn0;
    bit seen;
    pv0       = pv_cnt_a;
    dn0       = done_cnt_a;
    seen      = 1'b0;
    pix_mode  = pm;
    coef_mode = cm;
    start_a   = 1'b1;
    push_frame(AW, AH, AK, cyc + 1, 1'b0);
    for (int rel = 1; rel <= 200 && !seen; rel++) begin
      @(negedge clk);
      start_a = (rel == pulse_rel);
      if (done_a) seen = 1'b1;
    end
    start_a = 1'b0;
    chk({tag, "_done_seen"}, longint'(seen), 1);
    chk({tag, "_done_rd"}, longint'(read_data_a), 0);
    chk({tag, "_done_kv"}, longint'(kernel_val_a), 0);
    repeat (5) @(negedge clk);
    chk({tag, "_pv_count"}, longint'(pv_cnt_a - pv0), 12);
    chk({tag, "_done_count"}, longint'(done_cnt_a - dn0), 1);
    chk({tag, "_busy_after"}, longint'(busy_a), 0);
    chk({tag, "_pending"}, longint'(q_a.size()), 0);
  endtask

  initial begin
    int pv0, dn0;
    bit fin;
    //        rel addr coef en busy pv done rd kv
    tab[0]  = '{0,   0,  0,  0, 0,  0, 0,  0, 0};
    tab[1]  = '{1,   0,  0,  1, 1,  0, 0,  0, 0};
    tab[2]  = '{2,   1,  1,  1, 1,  0, 0,  0, 0};
    tab[3]  = '{3,   2,  2,  1, 1,  0, 0,  0, 1};
    tab[4]  = '{4,   6,  3,  1, 1,  0, 0,  1, 1};
    tab[5]  = '{9,   14, 8,  1, 1,  0, 0, 12, 1};
    tab[6]  = '{10,  1,  0,  1, 1,  0, 0, 13, 1};
    tab[7]  = '{11,  2,  1,  1, 1,  1, 0, 14, 1};
    tab[8]  = '{36,  17, 8,  1, 1,  0, 0, 15, 1};
    tab[9]  = '{37,  6,  0,  1, 1,  0, 0, 16, 1};
    tab[10] = '{38,  7,  1,  1, 1,  1, 0, 17, 1};
    tab[11] = '{108, 29, 8,  1, 1,  0, 0, 27, 1};
    tab[12] = '{109, 0,  0,  0, 1,  0, 0, 28, 1};
    tab[13] = '{110, 0,  0,  0, 1,  1, 0, 29, 1};
    tab[14] = '{111, 0,  0,  0, 0,  0, 1,  0, 0};
    tab[15] = '{112, 0,  0,  0, 0,  0, 0,  0, 0};

    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    #1;
    chk("rst_busy_a", longint'(busy_a), 0);
    chk("rst_done_a", longint'(done_a), 0);
    chk("rst_pv_a", longint'(pixel_valid_a), 0);
    chk("rst_rden_a", longint'(pix_rd_en_a), 0);
    chk("rst_addr_a", longint'(pix_addr_a), 0);
    chk("rst_busy_b", longint'(busy_b), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Full 6x5 frame: tap addresses, row wrap, pipeline latency, busy/done window.
    run_t1("t1");
    repeat (3) @(negedge clk);

    // Reset during tap 40, then the same frame must reproduce exactly.
    pix_mode  = 0;
    coef_mode = 0;
    start_a   = 1'b1;
    push_frame(AW, AH, AK, cyc + 1, 1'b0);
    for (int rel = 1; rel <= 40; rel++) begin
      @(negedge clk);
      if (rel == 1) start_a = 1'b0;
    end
    chk("t4_win_x_before", longint'(win_x_a), 3);
    reset = 1'b1;
    #1;
    chk("t4_rst_addr", longint'(pix_addr_a), 0);
    chk("t4_rst_coef", longint'(coef_addr_a), 0);
    chk("t4_rst_rden", longint'(pix_rd_en_a), 0);
    chk("t4_rst_busy", longint'(busy_a), 0);
    chk("t4_rst_done", longint'(done_a), 0);
    chk("t4_rst_pv", longint'(pixel_valid_a), 0);
    chk("t4_rst_rd", longint'(read_data_a), 0);
    chk("t4_rst_kv", longint'(kernel_val_a), 0);
    chk("t4_rst_winx", longint'(win_x_a), 0);
    chk("t4_rst_winy", longint'(win_y_a), 0);
    q_a.delete();
    pv0 = pv_cnt_a;
    dn0 = done_cnt_a;
    @(negedge clk);
    reset = 1'b0;
    repeat (130) @(negedge clk);
    chk("t4_no_pv", longint'(pv_cnt_a - pv0), 0);
    chk("t4_no_done", longint'(done_cnt_a - dn0), 0);
    run_t1("t4");
    repeat (3) @(negedge clk);

    // start pulses while busy (RUN, then DRAIN) are ignored; signed coefficient path.
    frame_a("t5", 0, 0, 20);
    frame_a("t6", 1, 1, 110);

    // K=1 4x4 with start held: two back-to-back frames of 16 single-tap windows.
    pix_mode  = 0;
    coef_mode = 0;
    pv0       = pv_cnt_b;
    dn0       = done_cnt_b;
    fin       = 1'b0;
    start_b   = 1'b1;
    push_frame(BW, BH, BK, cyc + 1, 1'b1);
    push_frame(BW, BH, BK, cyc + 1 + BW * BH + 4, 1'b1);
    for (int n = 0; n < 120 && !fin; n++) begin
      @(negedge clk);
      if (pv_cnt_b - pv0 >= 17) start_b = 1'b0;
      if (done_cnt_b - dn0 >= 2) fin = 1'b1;
    end
    start_b = 1'b0;
    chk("t3_finished", longint'(fin), 1);
    repeat (25) @(negedge clk);
    chk("t3_pv_count", longint'(pv_cnt_b - pv0), 32);
    chk("t3_done_count", longint'(done_cnt_b - dn0), 2);
    chk("t3_last_win_x", longint'(win_x_b), 3);
    chk("t3_last_win_y", longint'(win_y_b), 3);
    chk("t3_busy_after", longint'(busy_b), 0);
    chk("t3_pending", longint'(q_b.size()), 0);
    chk("final_pending_a", longint'(q_a.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
